// File: rtl/pattern_pkg.sv
// Shared encodings for the pattern loopback tester: pattern modes, FSM states,
// PRBS16 seed/taps and the checkerboard seed.
package pattern_pkg;

  typedef enum logic [1:0] {
    ModeCounter = 2'd0,
    ModeWalk    = 2'd1,
    ModePrbs    = 2'd2,
    ModeCheck   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam logic [15:0] PrbsSeed  = 16'hACE1;
  // Taps x^16, x^14, x^13, x^11 map to state bits 15, 13, 12, 10.
  localparam logic [15:0] PrbsTaps  = 16'hB400;
  localparam logic [15:0] CheckSeed = 16'h00A5;

  function automatic logic prbs_fb(input logic [15:0] s);
    return ^(s & PrbsTaps);
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Registered pattern generator: seeds on load, advances one step per enabled
// step cycle. All modes share one 16-bit state register; data is its low bits.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic             step,
  input  mode_e            mode,
  output logic [WIDTH-1:0] data
);

  logic [15:0]      state_q, state_d;
  logic [WIDTH-1:0] cur, rot;

  assign cur  = state_q[WIDTH-1:0];
  assign data = cur;

  always_comb begin
    rot    = '0;
    rot[0] = cur[WIDTH-1];
    for (int i = 1; i < int'(WIDTH); i++) begin
      rot[i] = cur[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      unique case (mode)
        ModeCounter: state_d = 16'h0000;
        ModeWalk:    state_d = 16'h0001;
        ModePrbs:    state_d = PrbsSeed;
        ModeCheck:   state_d = CheckSeed;
      endcase
    end else if (step) begin
      unique case (mode)
        ModeCounter: state_d = state_q + 16'h0001;
        ModeWalk:    state_d = 16'(rot);
        ModePrbs:    state_d = {state_q[14:0], prbs_fb(state_q)};
        ModeCheck:   state_d = ~state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pattern_loopback_tester.sv
// Pad loopback tester: drives a pattern, compares the looped-back data against a
// delayed copy, locks after a run of matches and counts errors while locked.
module pattern_loopback_tester
  import pattern_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOOP_LAT = 1,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] rx_data,
  output logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] tx_oe,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  localparam int unsigned MaxRun = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned RunW   = $clog2(MaxRun + 1);
  localparam int unsigned SupW   = $clog2(LOOP_LAT + 1);

  state_e                         state_q, state_d;
  mode_e                          mode_q, mode_d;
  logic [LOOP_LAT-1:0][WIDTH-1:0] dly_q, dly_d;
  logic [RunW-1:0]                run_q, run_d;
  logic [SupW-1:0]                sup_q, sup_d;
  logic [ERR_W-1:0]               err_q, err_d;

  logic             gen_load, gen_step;
  mode_e            gen_mode;
  logic [WIDTH-1:0] gen_data;
  logic [WIDTH-1:0] expected;
  logic             match;

  assign expected = dly_q[LOOP_LAT-1];
  assign match    = (rx_data == expected);

  pattern_gen #(
    .WIDTH(WIDTH)
  ) u_gen (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .load (gen_load),
    .step (gen_step),
    .mode (gen_mode),
    .data (gen_data)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dly_d    = dly_q;
    run_d    = run_q;
    sup_d    = sup_q;
    err_d    = err_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    gen_mode = mode_q;

    if (ena) begin
      if (stop) begin
        state_d = StIdle;
        run_d   = '0;
      end else begin
        if (state_q != StIdle) begin
          gen_step = 1'b1;
          dly_d[0] = gen_data;
          for (int i = 1; i < int'(LOOP_LAT); i++) begin
            dly_d[i] = dly_q[i-1];
          end
        end
        case (state_q)
          StIdle: begin
            if (start) begin
              state_d  = StSync;
              mode_d   = mode_e'(mode);
              gen_mode = mode_e'(mode);
              gen_load = 1'b1;
              dly_d    = '0;
              sup_d    = SupW'(LOOP_LAT);
              run_d    = '0;
              err_d    = '0;
            end
          end
          StSync: begin
            if (sup_q != '0) begin
              sup_d = sup_q - 1'b1;
            end else if (!match) begin
              run_d = '0;
            end else if (run_q == RunW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end
          StLocked: begin
            if (match) begin
              run_d = '0;
            end else begin
              if (err_q != '1) begin
                err_d = err_q + 1'b1;
              end
              if (run_q == RunW'(LOSS_CNT - 1)) begin
                state_d = StSync;
                run_d   = '0;
              end else begin
                run_d = run_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = StIdle;
            run_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= ModeCounter;
      dly_q   <= '0;
      run_q   <= '0;
      sup_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dly_q   <= dly_d;
      run_q   <= run_d;
      sup_q   <= sup_d;
      err_q   <= err_d;
    end
  end

  // Generator keeps its last value after a stop; gating by busy keeps tx at 0 in idle.
  assign busy    = (state_q != StIdle);
  assign locked  = (state_q == StLocked);
  assign tx_data = busy ? gen_data : '0;
  assign tx_oe   = busy ? '1 : '0;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_pattern_loopback_tester.sv
// Directed bench: two DUTs (default and ERR_W=4), each fed its own one-cycle loopback
// register with an optional bit-flip mask on rx.
module tb_pattern_loopback_tester;

  logic       clk = 1'b0;
  logic       rst, ena, start, stop;
  logic [1:0] mode;
  logic [7:0] rx_q, rx2_q, flip, flip2;
  logic [7:0] rx, rx2;
  logic [7:0] tx, oe, err, tx2, oe2;
  logic [3:0] err2;
  logic       locked, busy, locked2, busy2;

  int checks   = 0;
  int failures = 0;

  assign rx  = rx_q ^ flip;
  assign rx2 = rx2_q ^ flip2;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q  <= '0;
      rx2_q <= '0;
    end else if (ena) begin
      rx_q  <= tx;
      rx2_q <= tx2;
    end
  end

  pattern_loopback_tester u_dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .rx_data (rx),
    .tx_data (tx),
    .tx_oe   (oe),
    .locked  (locked),
    .err_cnt (err),
    .busy    (busy)
  );

  pattern_loopback_tester #(
    .ERR_W(4)
  ) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .rx_data (rx2),
    .tx_data (tx2),
    .tx_oe   (oe2),
    .locked  (locked2),
    .err_cnt (err2),
    .busy    (busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    flip = '0; flip2 = '0;
    tick();
    tick();
    checks++; if (tx !== 8'h00) begin failures++; $display("FAIL reset_tx got=%h exp=00", tx); end
    checks++; if (oe !== 8'h00) begin failures++; $display("FAIL reset_oe got=%h exp=00", oe); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (err !== 8'h00) begin failures++; $display("FAIL reset_err got=%h exp=00", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_counter_lock();
    logic found;
    do_start(2'd0);
    checks++; if (tx !== 8'h00) begin failures++; $display("FAIL cnt_seed got=%h exp=00", tx); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cnt_busy got=%b exp=1", busy); end
    checks++; if (oe !== 8'hFF) begin failures++; $display("FAIL cnt_oe got=%h exp=FF", oe); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL cnt_early_lock k=%0d got=%b exp=0", k, locked); end
    end
    tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL cnt_lock got=%b exp=1", locked); end
    checks++; if (tx !== 8'h05) begin failures++; $display("FAIL cnt_tx5 got=%h exp=05", tx); end
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (tx == 8'hFF) found = 1'b1;
      else tick();
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL cnt_reach_ff got=%b exp=1", found); end
    tick();
    checks++; if (tx !== 8'h00) begin failures++; $display("FAIL cnt_wrap got=%h exp=00", tx); end
    repeat (300) tick();
    checks++; if (err !== 8'h00) begin failures++; $display("FAIL cnt_err got=%h exp=00", err); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL cnt_still_locked got=%b exp=1", locked); end
  endtask

  task automatic test_prbs_errors();
    do_stop();
    do_start(2'd2);
    checks++; if (tx !== 8'hE1) begin failures++; $display("FAIL prbs_seed got=%h exp=E1", tx); end
    tick();
    checks++; if (tx !== 8'hC3) begin failures++; $display("FAIL prbs_step got=%h exp=C3", tx); end
    repeat (4) tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL prbs_lock got=%b exp=1", locked); end
    flip = 8'h01;
    repeat (3) tick();
    flip = 8'h00;
    checks++; if (err !== 8'd3) begin failures++; $display("FAIL prbs_err3 got=%0d exp=3", err); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL prbs_hold got=%b exp=1", locked); end
    repeat (3) tick();
    checks++; if (err !== 8'd3) begin failures++; $display("FAIL prbs_err3_after got=%0d exp=3", err); end
    do_stop();
    do_start(2'd2);
    repeat (5) tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL prbs_relock got=%b exp=1", locked); end
    checks++; if (err !== 8'd0) begin failures++; $display("FAIL prbs_err_clear got=%0d exp=0", err); end
    flip = 8'h01;
    repeat (3) tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL prbs_3miss got=%b exp=1", locked); end
    tick();
    flip = 8'h00;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL prbs_loss got=%b exp=0", locked); end
    checks++; if (err !== 8'd4) begin failures++; $display("FAIL prbs_err4 got=%0d exp=4", err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prbs_sync_busy got=%b exp=1", busy); end
  endtask

  task automatic test_walk_check();
    logic [7:0] e;
    do_stop();
    do_start(2'd1);
    for (int k = 0; k <= 8; k++) begin
      e = 8'h01 << (k % 8);
      checks++; if (tx !== e) begin failures++; $display("FAIL walk k=%0d got=%h exp=%h", k, tx, e); end
      tick();
    end
    do_stop();
    do_start(2'd3);
    e = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      checks++; if (tx !== e) begin failures++; $display("FAIL check k=%0d got=%h exp=%h", k, tx, e); end
      e = ~e;
      tick();
    end
  endtask

  task automatic test_start_stop();
    do_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ss_busy got=%b exp=0", busy); end
    checks++; if (oe !== 8'h00) begin failures++; $display("FAIL ss_oe got=%h exp=00", oe); end
    checks++; if (tx !== 8'h00) begin failures++; $display("FAIL ss_tx got=%h exp=00", tx); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ss_busy_later got=%b exp=0", busy); end
  endtask

  task automatic test_ena_freeze();
    do_start(2'd0);
    repeat (5) tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL frz_lock got=%b exp=1", locked); end
    flip = 8'h01;
    repeat (2) tick();
    flip = 8'h00;
    checks++; if (tx !== 8'h07) begin failures++; $display("FAIL frz_tx_pre got=%h exp=07", tx); end
    checks++; if (err !== 8'd2) begin failures++; $display("FAIL frz_err_pre got=%0d exp=2", err); end
    ena = 1'b0;
    repeat (5) tick();
    checks++; if (tx !== 8'h07) begin failures++; $display("FAIL frz_tx got=%h exp=07", tx); end
    checks++; if (err !== 8'd2) begin failures++; $display("FAIL frz_err got=%0d exp=2", err); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL frz_locked got=%b exp=1", locked); end
    ena = 1'b1;
    tick();
    checks++; if (tx !== 8'h08) begin failures++; $display("FAIL frz_resume got=%h exp=08", tx); end
    checks++; if (err !== 8'd2) begin failures++; $display("FAIL frz_err_resume got=%0d exp=2", err); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx !== 8'h00) begin failures++; $display("FAIL arst_tx got=%h exp=00", tx); end
    checks++; if (oe !== 8'h00) begin failures++; $display("FAIL arst_oe got=%h exp=00", oe); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL arst_locked got=%b exp=0", locked); end
    checks++; if (err !== 8'h00) begin failures++; $display("FAIL arst_err got=%h exp=00", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    tick();
    do_start(2'd0);
    checks++; if (tx !== 8'h00) begin failures++; $display("FAIL arst_restart_tx got=%h exp=00", tx); end
    repeat (4) tick();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL arst_early got=%b exp=0", locked); end
    tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL arst_relock got=%b exp=1", locked); end
  endtask

  task automatic test_saturate();
    do_stop();
    do_start(2'd0);
    repeat (5) tick();
    checks++; if (locked2 !== 1'b1) begin failures++; $display("FAIL sat_lock got=%b exp=1", locked2); end
    for (int r = 0; r < 20; r++) begin
      flip2 = 8'h01;
      tick();
      flip2 = 8'h00;
      tick();
      tick();
      if (r == 13) begin
        checks++; if (err2 !== 4'd14) begin failures++; $display("FAIL sat_err14 got=%0d exp=14", err2); end
      end
    end
    checks++; if (err2 !== 4'd15) begin failures++; $display("FAIL sat_err15 got=%0d exp=15", err2); end
    checks++; if (locked2 !== 1'b1) begin failures++; $display("FAIL sat_locked got=%b exp=1", locked2); end
  endtask

  initial begin
    test_reset();
    test_counter_lock();
    test_prbs_errors();
    test_walk_check();
    test_start_stop();
    test_ena_freeze();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
